// File: rtl/wave_gen_core.sv
// DDS waveform core: 16-bit phase accumulator feeding saw/square/sine shaping, attenuation and a registered DAC sample.
// Define WAVE_GEN_SINE_EN to build the quarter-wave sine table; without it wave_sel=2 outputs zero like the reserved code.
module wave_gen_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  wave_sel,
    input  logic [11:0] state_freq,
    input  logic [2:0]  state_amp,
    input  logic [7:0]  state_phase,
    output logic [13:0] DAC_in
);

    logic [15:0]        r_acc;
    logic [13:0]        r_dac;

    logic [13:0]        w_phase;
    logic [13:0]        w_raw;
    logic               w_valid;
    logic signed [13:0] w_centered;
    logic signed [13:0] w_shifted;
    logic [13:0]        w_scaled;

    // The phase offset has zero low bits, so p[15:2] needs only acc[15:2].
    assign w_phase = r_acc[15:2] + {state_phase, 6'd0};

`ifdef WAVE_GEN_SINE_EN
    logic [1:0]  w_quad;
    logic [5:0]  w_idx;
    logic [12:0] w_mag;
    logic [13:0] w_sine;

    assign w_quad = w_phase[13:12];
    assign w_idx  = w_quad[0] ? (6'd63 - w_phase[11:6]) : w_phase[11:6];

    always_comb begin
        w_mag = 13'd0;
        case (w_idx)
            6'd0:  w_mag = 13'd101;   6'd1:  w_mag = 13'd301;   6'd2:  w_mag = 13'd502;   6'd3:  w_mag = 13'd703;
            6'd4:  w_mag = 13'd903;   6'd5:  w_mag = 13'd1102;  6'd6:  w_mag = 13'd1301;  6'd7:  w_mag = 13'd1499;
            6'd8:  w_mag = 13'd1696;  6'd9:  w_mag = 13'd1893;  6'd10: w_mag = 13'd2088;  6'd11: w_mag = 13'd2281;
            6'd12: w_mag = 13'd2474;  6'd13: w_mag = 13'd2665;  6'd14: w_mag = 13'd2854;  6'd15: w_mag = 13'd3041;
            6'd16: w_mag = 13'd3227;  6'd17: w_mag = 13'd3411;  6'd18: w_mag = 13'd3593;  6'd19: w_mag = 13'd3772;
            6'd20: w_mag = 13'd3950;  6'd21: w_mag = 13'd4124;  6'd22: w_mag = 13'd4297;  6'd23: w_mag = 13'd4467;
            6'd24: w_mag = 13'd4634;  6'd25: w_mag = 13'd4798;  6'd26: w_mag = 13'd4960;  6'd27: w_mag = 13'd5118;
            6'd28: w_mag = 13'd5274;  6'd29: w_mag = 13'd5426;  6'd30: w_mag = 13'd5575;  6'd31: w_mag = 13'd5720;
            6'd32: w_mag = 13'd5863;  6'd33: w_mag = 13'd6001;  6'd34: w_mag = 13'd6136;  6'd35: w_mag = 13'd6267;
            6'd36: w_mag = 13'd6395;  6'd37: w_mag = 13'd6519;  6'd38: w_mag = 13'd6638;  6'd39: w_mag = 13'd6754;
            6'd40: w_mag = 13'd6866;  6'd41: w_mag = 13'd6973;  6'd42: w_mag = 13'd7077;  6'd43: w_mag = 13'd7176;
            6'd44: w_mag = 13'd7271;  6'd45: w_mag = 13'd7361;  6'd46: w_mag = 13'd7447;  6'd47: w_mag = 13'd7528;
            6'd48: w_mag = 13'd7605;  6'd49: w_mag = 13'd7678;  6'd50: w_mag = 13'd7745;  6'd51: w_mag = 13'd7809;
            6'd52: w_mag = 13'd7867;  6'd53: w_mag = 13'd7921;  6'd54: w_mag = 13'd7969;  6'd55: w_mag = 13'd8013;
            6'd56: w_mag = 13'd8053;  6'd57: w_mag = 13'd8087;  6'd58: w_mag = 13'd8116;  6'd59: w_mag = 13'd8141;
            6'd60: w_mag = 13'd8161;  6'd61: w_mag = 13'd8176;  6'd62: w_mag = 13'd8185;  6'd63: w_mag = 13'd8190;
            default: w_mag = 13'd0;
        endcase
    end

    assign w_sine = w_quad[1] ? (14'd8192 - {1'b0, w_mag}) : (14'd8192 + {1'b0, w_mag});
`endif

    always_comb begin
        w_raw   = 14'd0;
        w_valid = 1'b0;
        case (wave_sel)
            2'd0: begin
                w_raw   = w_phase;
                w_valid = 1'b1;
            end
            2'd1: begin
                w_raw   = {14{w_phase[13]}};
                w_valid = 1'b1;
            end
`ifdef WAVE_GEN_SINE_EN
            2'd2: begin
                w_raw   = w_sine;
                w_valid = 1'b1;
            end
`endif
            default: begin
                w_raw   = 14'd0;
                w_valid = 1'b0;
            end
        endcase
    end

    // Offset binary <-> two's complement around 8192 is a flip of the MSB, so the
    // signed shift stays exact in 14 bits with no spare sign bit.
    assign w_centered = {~w_raw[13], w_raw[12:0]};
    assign w_shifted  = w_centered >>> state_amp;
    assign w_scaled   = {~w_shifted[13], w_shifted[12:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= 16'd0;
            r_dac <= 14'd0;
        end else if (en) begin
            r_acc <= r_acc + {4'h0, state_freq};
            r_dac <= w_valid ? w_scaled : 14'd0;
        end else begin
            r_dac <= 14'd0;
        end
    end

    assign DAC_in = r_dac;

endmodule

// File: tb/tb_wave_gen_core.sv
// Self-checking bench for wave_gen_core: vector table, hand sequences and a randomized model run.
// Sine expectations follow WAVE_GEN_SINE_EN as given to the build.
module tb_wave_gen_core;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  wave_sel;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic [13:0] DAC_in;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          sb_q[$];
    logic [15:0] m_acc    = 16'h0;

    typedef struct {
        logic        r;
        logic        e;
        logic [1:0]  s;
        logic [11:0] f;
        logic [2:0]  a;
        logic [7:0]  ph;
        int          exp;
        string       nm;
    } vec_t;

    vec_t vec_q[$];

`ifdef WAVE_GEN_SINE_EN
    localparam int SIN_0   = 8293;
    localparam int SIN_64  = 16382;
    localparam int SIN_128 = 8091;
    localparam int SIN_192 = 2;
    localparam int SIN_64_A2 = 10239;
`else
    localparam int SIN_0   = 0;
    localparam int SIN_64  = 0;
    localparam int SIN_128 = 0;
    localparam int SIN_192 = 0;
    localparam int SIN_64_A2 = 0;
`endif

    wave_gen_core u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wave_sel    (wave_sel),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .DAC_in      (DAC_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int model_out(input logic r, input logic e, input logic [1:0] s,
                                     input logic [2:0] a, input logic [7:0] ph, input logic [15:0] acc);
        logic [15:0] p;
        int raw;
        int c;
        bit ok;
        p   = acc + {ph, 8'h00};
        raw = 0;
        ok  = 1'b0;
        if (!r || !e) return 0;
        case (s)
            2'd0: begin raw = int'(p[15:2]); ok = 1'b1; end
            2'd1: begin raw = p[15] ? 16383 : 0; ok = 1'b1; end
`ifdef WAVE_GEN_SINE_EN
            2'd2: begin
                int q, k, kk, mag;
                real v;
                q   = int'(p[15:14]);
                k   = int'(p[13:8]);
                kk  = (q % 2 == 1) ? 63 - k : k;
                v   = 8191.0 * $sin(3.141592653589793 * (real'(kk) + 0.5) / 128.0);
                mag = $rtoi(v + 0.5);
                raw = (q < 2) ? 8192 + mag : 8192 - mag;
                ok  = 1'b1;
            end
`endif
            default: ok = 1'b0;
        endcase
        if (!ok) return 0;
        c = raw - 8192;
        c = c >>> a;
        return c + 8192;
    endfunction

    // exp < 0 asks the model for the expected sample.
    task automatic apply(input logic r, input logic e, input logic [1:0] s, input logic [11:0] f,
                         input logic [2:0] a, input logic [7:0] ph, input int exp, input string nm);
        int want;
        int got;
        @(negedge clk);
        rst_n       = r;
        en          = e;
        wave_sel    = s;
        state_freq  = f;
        state_amp   = a;
        state_phase = ph;
        want = (exp < 0) ? model_out(r, e, s, a, ph, m_acc) : exp;
        sb_q.push_back(want);
        if (!r)     m_acc = 16'h0;
        else if (e) m_acc = m_acc + {4'h0, f};
        @(posedge clk);
        #1;
        got  = int'(DAC_in);
        want = sb_q.pop_front();
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: DAC_in=%0d expected %0d", nm, got, want);
    endtask

    task automatic tv(input logic r, input logic e, input logic [1:0] s, input logic [11:0] f,
                      input logic [2:0] a, input logic [7:0] ph, input int exp, input string nm);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.f = f; v.a = a; v.ph = ph; v.exp = exp; v.nm = nm;
        vec_q.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wave_sel = 2'd0;
        state_freq = 12'd0; state_amp = 3'd0; state_phase = 8'd0;

        tv(0, 1, 0, 100, 0, 0,     0, "reset_hold_0");
        tv(0, 1, 0, 100, 0, 0,     0, "reset_hold_1");
        tv(1, 1, 0, 100, 0, 0,     0, "first_sample");
        tv(1, 1, 0, 100, 0, 0,    25, "saw_acc100");
        tv(1, 1, 1, 100, 0, 0,     0, "square_low");
        tv(1, 1, 3, 100, 0, 0,     0, "reserved_sel");
        tv(1, 1, 0, 100, 0, 0,   100, "saw_after_reserved");
        tv(1, 0, 0, 100, 0, 0,     0, "en_low");
        tv(1, 1, 0,   0, 0, 0,   125, "saw_held_acc");
        tv(1, 1, 0,   0, 1, 0,  4158, "saw_amp1");
        tv(1, 1, 1,   0, 0, 128, 16383, "square_phase128");
        tv(1, 1, 1,   0, 1, 128, 12287, "square_hi_amp1");
        tv(1, 1, 1,   0, 7, 0,  8128, "square_lo_amp7");
        tv(1, 1, 1,   0, 7, 128, 8255, "square_hi_amp7");
        tv(1, 1, 0,   0, 0, 255,   61, "saw_phase_wrap");
        tv(0, 1, 0,   0, 0, 0,     0, "reset_mid");
        tv(1, 1, 2,   0, 0, 0,  SIN_0,   "sine_ph0");
        tv(1, 1, 2,   0, 0, 64, SIN_64,  "sine_ph64");
        tv(1, 1, 2,   0, 0, 128, SIN_128, "sine_ph128");
        tv(1, 1, 2,   0, 0, 192, SIN_192, "sine_ph192");
        tv(1, 1, 2,   0, 2, 64, SIN_64_A2, "sine_ph64_amp2");

        foreach (vec_q[i])
            apply(vec_q[i].r, vec_q[i].e, vec_q[i].s, vec_q[i].f, vec_q[i].a, vec_q[i].ph,
                  vec_q[i].exp, vec_q[i].nm);

        // Saw ramp over a full period and through the wrap.
        apply(0, 1, 0, 4, 0, 0, 0, "saw_ramp_reset");
        for (int i = 0; i < 16386; i++)
            apply(1, 1, 0, 4, 0, 0, i % 16384, "saw_ramp");

        // Square at 1/256 of the clock: 128 low, 128 high.
        apply(0, 1, 1, 256, 0, 0, 0, "square_reset");
        for (int i = 0; i < 512; i++)
            apply(1, 1, 1, 256, 0, 0, ((i / 128) % 2 == 1) ? 16383 : 0, "square_period");

        // Enable drop and resume, then a mid-run reset.
        apply(0, 1, 0, 4, 0, 0, 0, "pause_reset");
        for (int i = 0; i <= 10; i++) apply(1, 1, 0, 4, 0, 0, i, "pause_pre");
        for (int i = 0; i < 5; i++)   apply(1, 0, 0, 4, 0, 0, 0, "pause_off");
        for (int i = 11; i < 16; i++) apply(1, 1, 0, 4, 0, 0, i, "pause_resume");
        apply(0, 1, 0, 4, 0, 0, 0, "midrun_reset");
        for (int i = 0; i < 3; i++)   apply(1, 1, 0, 4, 0, 0, i, "midrun_restart");

        // Randomized operation against the model, starting from a known acc.
        apply(0, 1, 0, 0, 0, 0, 0, "rand_reset");
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            r = ($urandom_range(0, 24) != 0);
            e = ($urandom_range(0, 5) != 0);
            apply(r, e, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), -1, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
